// File: rtl/cd_pila.sv
// rtl/cd_pila.sv - parametrised single-cycle datapath with return-address stack and Z/C flags
module cd_pila #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 10,
    parameter int NREG   = 16,
    parameter int STK_D  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [31:0]       instr,
    output logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] Datos,
    output logic [DATA_W-1:0] Direcciones,
    input  logic              s_inc,
    input  logic              s_mux_alu,
    input  logic              s_signext,
    input  logic              s_mux_datos,
    input  logic              we3,
    input  logic              wez,
    input  logic [2:0]        op_alu,
    input  logic              call,
    input  logic              ret,
    output logic              z,
    output logic              c,
    output logic [5:0]        opcode,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_err
);
    localparam int SA_W = $clog2(STK_D);

    logic [DATA_W-1:0] rf [NREG];
    logic [PC_W-1:0]   stk [STK_D];
    logic [SA_W:0]     cnt;
    logic [SA_W:0]     cnt_m1;

    logic [3:0]        wa, ra1, ra2;
    logic [DATA_W-1:0] rd1, rd2, imm, a_op, alu_res, wd;
    logic              alu_c;
    logic [DATA_W:0]   sum, diff;
    logic [PC_W-1:0]   pc_inc, pc_nxt;
    logic              do_push, do_pop, err_set;

    assign wa          = instr[25:22];
    assign ra1         = instr[21:18];
    assign ra2         = instr[17:14];
    assign opcode      = instr[31:26];
    assign Direcciones = rd2;

    // R0 and out-of-range addresses read as zero
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != 4'd0 && int'(ra1) < NREG) rd1 = rf[ra1];
        if (ra2 != 4'd0 && int'(ra2) < NREG) rd2 = rf[ra2];
    end

    assign imm  = s_signext ? DATA_W'($signed(instr[15:0])) : DATA_W'(instr[15:0]);
    assign a_op = s_mux_alu ? imm : rd1;
    assign sum  = {1'b0, a_op} + {1'b0, rd2};
    assign diff = {1'b0, a_op} - {1'b0, rd2};

    always_comb begin
        alu_c   = 1'b0;
        alu_res = a_op;
        case (op_alu)
            3'b000: alu_res = a_op;
            3'b001: alu_res = ~a_op;
            3'b010: begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  end
            3'b011: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; end
            3'b100: alu_res = a_op & rd2;
            3'b101: alu_res = a_op | rd2;
            3'b110: alu_res = -a_op;
            3'b111: alu_res = -rd2;
            default: alu_res = a_op;
        endcase
    end

    assign wd = s_mux_datos ? Datos : alu_res;

    assign stk_full  = (cnt == (SA_W+1)'(STK_D));
    assign stk_empty = (cnt == '0);
    assign cnt_m1    = cnt - 1'b1;
    assign pc_inc    = pc + 1'b1;

    // ret outranks call; a simultaneous call is dropped and flagged
    always_comb begin
        pc_nxt  = pc_inc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        err_set = 1'b0;
        if (ret) begin
            if (stk_empty) begin
                err_set = 1'b1;
            end else begin
                do_pop = 1'b1;
                pc_nxt = stk[cnt_m1[SA_W-1:0]];
            end
            if (call) err_set = 1'b1;
        end else if (call) begin
            pc_nxt = instr[PC_W-1:0];
            if (stk_full) err_set = 1'b1;
            else          do_push = 1'b1;
        end else if (!s_inc) begin
            pc_nxt = instr[PC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= '0;
            z       <= 1'b0;
            c       <= 1'b0;
            cnt     <= '0;
            stk_err <= 1'b0;
        end else if (en) begin
            pc <= pc_nxt;
            if (wez) begin
                z <= (alu_res == '0);
                c <= alu_c;
            end
            if (do_push)      cnt <= cnt + 1'b1;
            else if (do_pop)  cnt <= cnt_m1;
            if (err_set) stk_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en && we3 && wa != 4'd0 && int'(wa) < NREG) rf[wa] <= wd;
        if (en && do_push) stk[cnt[SA_W-1:0]] <= pc_inc;
    end
endmodule

// File: doc/cd_pila.md
Name: cd_pila

Overview:
- Parametrised single-cycle CPU datapath, second generation.
- Adds:
  - generic data width and register count;
  - a hardware return-address stack for call/return;
  - a carry flag beside the zero flag;
  - a global stall enable.
- Instruction and data memories are external.
- Sits between the control unit (which decodes opcode) and the memory/IO fabric.

Parameters:
- DATA_W, 16, datapath/register width; must be >= 16.
- PC_W, 10, program counter width; must be <= 14.
- NREG, 16, register file entries; fixed field width 4, so NREG <= 16.
- STK_D, 8, return stack depth (entries); power of 2, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  1 = commit this cycle's state updates; 0 = full stall.
- instr  in  32  instruction word addressed by pc.
- pc  out  PC_W  current program counter.
- Datos  in  DATA_W  data read from memory/IO.
- Direcciones  out  DATA_W  = rd2; address/write data toward memory.
- s_inc  in  1  1 = sequential pc+1; 0 = jump to instr[PC_W-1:0].
- s_mux_alu  in  1  1 = ALU A operand is the immediate; 0 = rd1.
- s_signext  in  1  1 = sign-extend instr[15:0]; 0 = zero-extend.
- s_mux_datos  in  1  1 = write-back from Datos; 0 = from the ALU.
- we3  in  1  register file write enable.
- wez  in  1  Z/C flag write enable.
- op_alu  in  3  ALU operation.
- call  in  1  push pc+1 and jump to instr[PC_W-1:0].
- ret  in  1  pop stack top into pc.
- z  out  1  zero flag (registered).
- c  out  1  carry/borrow flag (registered).
- opcode  out  6  = instr[31:26].
- stk_full  out  1  stack holds STK_D entries.
- stk_empty  out  1  stack holds 0 entries.
- stk_err  out  1  sticky overflow/underflow/conflict error.

Behaviour:
- Reset (asynchronous, reset=0):
  - pc=0, z=0, c=0, stack count=0, stk_err=0;
  - stk_empty=1, stk_full=0;
  - register file and stack contents are not reset.
- en=0: no register, pc, flag, stack or error update. Outputs remain combinational from the current state and instr.
- Fields:
  - write register = instr[25:22], read1 = instr[21:18], read2 = instr[17:14];
  - immediate = instr[15:0] extended to DATA_W per s_signext.
- Register file:
  - two combinational reads, one synchronous write (we3 & en);
  - R0 reads 0 and ignores writes;
  - a read of the address being written returns the old value in the same cycle;
  - addresses >= NREG read 0 and ignore writes.
- ALU, with A = operand mux and B = rd2; the result is DATA_W bits and wraps:
  - 000 A;
  - 001 ~A;
  - 010 A+B, c = carry out;
  - 011 A-B, c = borrow (1 when A<B unsigned);
  - 100 A&B;
  - 101 A|B;
  - 110 -A;
  - 111 -B.
- Flags:
  - on wez & en, z <= (result==0);
  - c <= carry for 010/011, 0 for all other ops.
- Next pc, priority order:
  - ret: valid pop loads stack top; on an empty stack, pc+1 and stk_err<=1.
  - call: if not full, pushes pc+1 and loads target. If full, the push is dropped, stk_err<=1 and the jump still happens.
  - s_inc=0: instr[PC_W-1:0].
  - otherwise pc+1, wrapping modulo 2^PC_W.
- call & ret in the same cycle:
  - ret executes, call is ignored, stk_err<=1.
- Stack behaviour:
  - LIFO;
  - stk_full/stk_empty are derived from the registered count;
  - stk_err clears only on reset.
- Latency: single cycle. Writes, flags, pc and stack all commit on the same edge.

Test Plan:
- Reset mid-run with pc=0x05A, z=1 asserted asynchronously -> pc=0, z=0, stk_empty=1 immediately, without waiting for a clock edge.
- Immediate 0xFFFF with s_signext=1 and op 000, written to R3, then 010 with R3+R3 (DATA_W=16) -> R3=0xFFFE, c=1, z=0.
- Sub 5-5 with wez=1 -> z=1, c=0; sub 3-5 -> z=0, c=1, result 0xFFFE. A write to R0 followed by a read -> 0.
- call at pc=4 to 0x020, call at 0x020 to 0x040, ret, ret -> pc sequence 0x020, 0x040, 0x021, 0x005; stk_empty=1, stk_err=0.
- STK_D+1 consecutive calls -> stk_full=1 after STK_D calls; the last call still jumps and stk_err=1. A ret on an empty stack -> pc+1, stk_err=1. call&ret together -> ret wins, stk_err=1.
- en=0 for 3 cycles with we3, wez and call asserted -> pc, registers, flags and stack count unchanged; en=1 resumes with a pc+1 step.
